// File: rtl/writeback_queue_if.sv
// Bundle of the writeback queue's producer handshake, write-port and bypass signals.
// The queue itself connects through the slave modport; the pipeline side uses the master modport.
interface writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Producer handshake
    logic             res_valid;
    logic             res_ready;
    logic [4:0]       res_addr;
    logic [WIDTH-1:0] res_data;

    // Pipeline control
    logic             flush;
    logic             hold;

    // Register-file write port
    logic             wb_enable;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;

    // Bypass queries
    logic [4:0]       rd_addr_1;
    logic [4:0]       rd_addr_2;
    logic             byp_hit_1;
    logic             byp_hit_2;
    logic [WIDTH-1:0] byp_data_1;
    logic [WIDTH-1:0] byp_data_2;

    // Occupancy
    logic [CW-1:0]    count;

    modport slave (
        input  res_valid, res_addr, res_data, flush, hold, rd_addr_1, rd_addr_2,
        output res_ready, wb_enable, wb_addr, wb_data,
               byp_hit_1, byp_hit_2, byp_data_1, byp_data_2, count
    );

    modport master (
        output res_valid, res_addr, res_data, flush, hold, rd_addr_1, rd_addr_2,
        input  res_ready, wb_enable, wb_addr, wb_data,
               byp_hit_1, byp_hit_2, byp_data_1, byp_data_2, count
    );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: a DEPTH-entry circular FIFO of (register index, value) results
// feeding one registered register-file write stage, with two combinational bypass
// ports that return the newest still-pending value for a queried register.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_queue_if.slave io_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // FIFO storage kept in flops: the bypass search needs every entry at once
    logic [4:0]       r_mem_addr [DEPTH];
    logic [WIDTH-1:0] r_mem_data [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_wb_enable;
    logic [4:0]       r_wb_addr;
    logic [WIDTH-1:0] r_wb_data;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;

    logic [AW-1:0]    w_age     [DEPTH];
    logic [DEPTH-1:0] w_slot_valid;
    logic [DEPTH-1:0] w_match_1;
    logic [DEPTH-1:0] w_match_2;

    logic             w_hit_1;
    logic             w_hit_2;
    logic [WIDTH-1:0] w_data_1;
    logic [WIDTH-1:0] w_data_2;

    // Readiness depends only on occupancy, so a same-cycle pop never frees a slot early.
    assign w_ready = (r_count < CW'(DEPTH));
    // x0 results complete the handshake but are never stored; a flush edge swallows the transfer.
    assign w_push  = io_bus.res_valid && w_ready && (io_bus.res_addr != 5'd0) && !io_bus.flush;
    assign w_pop   = (r_count != '0) && !io_bus.hold && !io_bus.flush;

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (io_bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: contents need no reset because validity comes from the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= io_bus.res_addr;
            r_mem_data[r_wr_ptr] <= io_bus.res_data;
        end
    end

    // Write-port stage: strobe for exactly the cycle after a pop, address/data held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_enable <= 1'b0;
            r_wb_addr   <= 5'd0;
            r_wb_data   <= '0;
        end else if (w_pop) begin
            r_wb_enable <= 1'b1;
            r_wb_addr   <= r_mem_addr[r_rd_ptr];
            r_wb_data   <= r_mem_data[r_rd_ptr];
        end else begin
            r_wb_enable <= 1'b0;
        end
    end

    // Per-slot validity (slot age relative to the head) and bypass address matches
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_age[gi]        = AW'(gi) - r_rd_ptr;
            assign w_slot_valid[gi] = ({1'b0, w_age[gi]} < r_count);
            assign w_match_1[gi]    = w_slot_valid[gi] && (io_bus.rd_addr_1 != 5'd0)
                                      && (r_mem_addr[gi] == io_bus.rd_addr_1);
            assign w_match_2[gi]    = w_slot_valid[gi] && (io_bus.rd_addr_2 != 5'd0)
                                      && (r_mem_addr[gi] == io_bus.rd_addr_2);
        end
    endgenerate

    // Bypass search from oldest (wb stage) to newest (tail); later matches override earlier ones
    always_comb begin
        w_hit_1  = 1'b0;
        w_hit_2  = 1'b0;
        w_data_1 = '0;
        w_data_2 = '0;
        if (r_wb_enable && (io_bus.rd_addr_1 != 5'd0) && (r_wb_addr == io_bus.rd_addr_1)) begin
            w_hit_1  = 1'b1;
            w_data_1 = r_wb_data;
        end
        if (r_wb_enable && (io_bus.rd_addr_2 != 5'd0) && (r_wb_addr == io_bus.rd_addr_2)) begin
            w_hit_2  = 1'b1;
            w_data_2 = r_wb_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match_1[AW'(r_rd_ptr + AW'(k))]) begin
                w_hit_1  = 1'b1;
                w_data_1 = r_mem_data[AW'(r_rd_ptr + AW'(k))];
            end
            if (w_match_2[AW'(r_rd_ptr + AW'(k))]) begin
                w_hit_2  = 1'b1;
                w_data_2 = r_mem_data[AW'(r_rd_ptr + AW'(k))];
            end
        end
    end

    assign io_bus.res_ready  = w_ready;
    assign io_bus.wb_enable  = r_wb_enable;
    assign io_bus.wb_addr    = r_wb_addr;
    assign io_bus.wb_data    = r_wb_data;
    assign io_bus.byp_hit_1  = w_hit_1;
    assign io_bus.byp_hit_2  = w_hit_2;
    assign io_bus.byp_data_1 = w_data_1;
    assign io_bus.byp_data_2 = w_data_2;
    assign io_bus.count      = r_count;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: a scoreboard of accepted results is filled
// as stimulus is driven and drained by a write-port monitor; scenario tasks add inline checks.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    writeback_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    bit last_acc;
    logic [36:0] sb [$];
    logic [36:0] mon_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: every strobe must match the oldest outstanding accepted result
    always @(posedge clk) begin
        #2;
        if (rst_n === 1'b1 && bus.wb_enable === 1'b1) begin
            checks++;
            wr_seen++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_order: got write addr=%0d data=%h, required no write",
                         bus.wb_addr, bus.wb_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({bus.wb_addr, bus.wb_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL wb_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.wb_addr, bus.wb_data, mon_exp[36:32], mon_exp[31:0]);
                end else begin
                    $display("write addr=%0d data=%h", bus.wb_addr, bus.wb_data);
                end
            end
        end
    end

    // One clock of stimulus, starting and ending at a falling edge; records accepted results
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic f, input logic h);
        bus.res_valid = v;
        bus.res_addr  = a;
        bus.res_data  = d;
        bus.flush     = f;
        bus.hold      = h;
        #1;
        last_acc = v && (bus.res_ready === 1'b1);
        if (last_acc && !f && a != 5'd0) sb.push_back({a, d});
        @(posedge clk);
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.count !== 3'd0)   begin errors++; $display("FAIL reset_count: got %0d, required 0", bus.count); end
        checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.res_ready); end
        checks++; if (bus.wb_enable !== 1'b0) begin errors++; $display("FAIL reset_wb_enable: got %b, required 0", bus.wb_enable); end
        checks++; if (bus.wb_addr !== 5'd0)   begin errors++; $display("FAIL reset_wb_addr: got %0d, required 0", bus.wb_addr); end
        checks++; if (bus.wb_data !== 32'd0)  begin errors++; $display("FAIL reset_wb_data: got %h, required 0", bus.wb_data); end
        $display("reset checked");
    endtask

    task automatic test_single();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        checks++; if (!last_acc) begin errors++; $display("FAIL single_accept: got 0, required 1"); end
        checks++; if (bus.wb_enable !== 1'b0) begin errors++; $display("FAIL single_latency_early: got %b, required 0", bus.wb_enable); end
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write: got en=%b addr=%0d data=%h, required en=1 addr=5 data=deadbeef",
                               bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.wb_enable !== 1'b0 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_one_cycle: got en=%b addr=%0d data=%h, required en=0 addr=5 data=deadbeef",
                               bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b1);
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d, required 4", bus.count); end
        checks++; if (bus.res_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b, required 0", bus.res_ready); end
        step(1'b1, 5'd9, 32'h999, 1'b0, 1'b1);
        checks++; if (last_acc || bus.count !== 3'd4) begin
            errors++; $display("FAIL fill_fifth: got accepted=%b count=%0d, required accepted=0 count=4", last_acc, bus.count);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            checks++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'(i)) begin
                errors++; $display("FAIL fill_drain: got en=%b addr=%0d, required en=1 addr=%0d", bus.wb_enable, bus.wb_addr, i);
            end
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.wb_enable !== 1'b0) begin errors++; $display("FAIL fill_done: got %b, required 0", bus.wb_enable); end
    endtask

    task automatic test_x0();
        int base;
        base = wr_seen;
        step(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
        checks++; if (!last_acc) begin errors++; $display("FAIL x0_handshake: got 0, required 1"); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL x0_count: got %0d, required 0", bus.count); end
        repeat (3) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (wr_seen !== base) begin errors++; $display("FAIL x0_write: got %0d writes, required 0", wr_seen - base); end
    endtask

    task automatic test_bypass();
        step(1'b1, 5'd3, 32'h11, 1'b0, 1'b1);
        step(1'b1, 5'd3, 32'h22, 1'b0, 1'b1);
        bus.rd_addr_1 = 5'd3;
        bus.rd_addr_2 = 5'd0;
        #1;
        checks++; if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 32'h22) begin
            errors++; $display("FAIL byp_newest: got hit=%b data=%h, required hit=1 data=22", bus.byp_hit_1, bus.byp_data_1);
        end
        checks++; if (bus.byp_hit_2 !== 1'b0 || bus.byp_data_2 !== 32'd0) begin
            errors++; $display("FAIL byp_x0: got hit=%b data=%h, required hit=0 data=0", bus.byp_hit_2, bus.byp_data_2);
        end
        bus.rd_addr_2 = 5'd7;
        #1;
        checks++; if (bus.byp_hit_2 !== 1'b0) begin errors++; $display("FAIL byp_miss: got %b, required 0", bus.byp_hit_2); end
        @(negedge clk);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 32'h22) begin
            errors++; $display("FAIL byp_wb_stage: got hit=%b data=%h, required hit=1 data=22", bus.byp_hit_1, bus.byp_data_1);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.byp_hit_1 !== 1'b0 || bus.byp_data_1 !== 32'd0) begin
            errors++; $display("FAIL byp_empty: got hit=%b data=%h, required hit=0 data=0", bus.byp_hit_1, bus.byp_data_1);
        end
        bus.rd_addr_1 = 5'd0;
        bus.rd_addr_2 = 5'd0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5'd12 + 5'(i), 32'hB000 + 32'(i), 1'b0, 1'b0);
            checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d, required 1", bus.count); end
        end
        repeat (2) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        int base;
        for (int i = 0; i < 3; i++) step(1'b1, 5'd10 + 5'(i), 32'hF000 + 32'(i), 1'b0, 1'b1);
        step(1'b1, 5'd13, 32'hBAD0BAD0, 1'b1, 1'b1);
        sb.delete();
        base = wr_seen;
        checks++; if (bus.count !== 3'd0 || bus.wb_enable !== 1'b0) begin
            errors++; $display("FAIL flush_state: got count=%0d en=%b, required count=0 en=0", bus.count, bus.wb_enable);
        end
        repeat (4) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (wr_seen !== base) begin errors++; $display("FAIL flush_discard: got %0d writes, required 0", wr_seen - base); end
    endtask

    task automatic test_wrap();
        int base;
        int sent;
        base = wr_seen;
        sent = 0;
        for (int i = 0; i < 200 && sent < 10; i++) begin
            step(1'b1, 5'd1 + 5'(sent), $urandom, 1'b0, 1'($urandom_range(0, 1)));
            if (last_acc) sent++;
        end
        for (int i = 0; i < 50 && sb.size() != 0; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (sb.size() != 0 || wr_seen - base != 10) begin
            errors++; $display("FAIL wrap_stream: got %0d writes, %0d left, required 10 writes, 0 left", wr_seen - base, sb.size());
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 5'd20, 32'hA0, 1'b0, 1'b1);
        step(1'b1, 5'd21, 32'hA1, 1'b0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.wb_enable !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b, required 1", bus.wb_enable); end
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        checks++; if (bus.wb_enable !== 1'b0 || bus.count !== 3'd0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0 || bus.res_ready !== 1'b1) begin
            errors++; $display("FAIL areset_now: got en=%b count=%0d addr=%0d data=%h ready=%b, required 0/0/0/0/1",
                               bus.wb_enable, bus.count, bus.wb_addr, bus.wb_data, bus.res_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd7, 32'h7777, 1'b0, 1'b0);
        checks++; if (!last_acc || bus.count !== 3'd1) begin
            errors++; $display("FAIL areset_first: got accepted=%b count=%0d, required 1/1", last_acc, bus.count);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd7) begin
            errors++; $display("FAIL areset_write: got en=%b addr=%0d, required en=1 addr=7", bus.wb_enable, bus.wb_addr);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_addr  = 5'd0;
        bus.res_data  = 32'd0;
        bus.flush     = 1'b0;
        bus.hold      = 1'b0;
        bus.rd_addr_1 = 5'd0;
        bus.rd_addr_2 = 5'd0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_single();
        test_fill();
        test_x0();
        test_bypass();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
